// File: rtl/spi_sample_capture_if.sv
// spi_sample_capture_if: SPI pins plus the sample-RAM read/handshake side of the capture block.
interface spi_sample_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
);
    logic              sck;
    logic              sdi;
    logic              ss;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              frame_done;
    logic              frame_ack;
    logic [ADDR_W-1:0] sample_count;
    logic              overflow;
    logic [7:0]        led;

    modport master (
        output sck, sdi, ss, rd_addr, frame_ack,
        input  rd_data, frame_done, sample_count, overflow, led
    );
    modport slave (
        input  sck, sdi, ss, rd_addr, frame_ack,
        output rd_data, frame_done, sample_count, overflow, led
    );
endinterface

// File: rtl/spi_sample_capture.sv
// spi_sample_capture: SPI slave that fills a sample RAM with one utterance and holds it until acked.
module spi_sample_capture #(
    parameter int DATA_W      = 8,
    parameter int NUM_SAMPLES = 5000,
    parameter int ADDR_W      = 13
) (
    input logic                 clk,
    input logic                 reset_n,
    spi_sample_capture_if.slave bus
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;

    state_t              state, state_nx;
    logic [2:0]          sck_r;
    logic [1:0]          sdi_r, ss_r;
    logic                sck_rise, ss_s, last_bit, byte_vld, we, at_last;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [DATA_W-1:0]   ram [2**ADDR_W];

    assign ss_s     = ss_r[1];
    assign sck_rise = sck_r[1] & ~sck_r[2];
    assign last_bit = bit_cnt == BW'(DATA_W-1);
    assign at_last  = wr_ptr == ADDR_W'(NUM_SAMPLES-1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_r    <= '0;
            sdi_r    <= '0;
            ss_r     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_vld <= 1'b0;
        end else begin
            sck_r    <= {sck_r[1:0], bus.sck};
            sdi_r    <= {sdi_r[0], bus.sdi};
            ss_r     <= {ss_r[0], bus.ss};
            byte_vld <= ss_s & sck_rise & last_bit;
            if (!ss_s)
                bit_cnt <= '0;
            else if (sck_rise) begin
                shreg   <= {shreg[DATA_W-2:0], sdi_r[1]};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        we       = (state == RECV) && byte_vld;
        state_nx = (state == IDLE && ss_s)           ? RECV :
                   (we && at_last)                   ? FULL :
                   (state == FULL && bus.frame_ack)  ? IDLE : state;
    end

    always_ff @(posedge clk)
        if (we)
            ram[wr_ptr] <= shreg;

    // in FULL an ack outranks a simultaneous byte, so overflow only sets when no ack is present
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            bus.sample_count <= '0;
            bus.led          <= '0;
            bus.overflow     <= 1'b0;
            bus.rd_data      <= '0;
        end else begin
            bus.rd_data <= ram[bus.rd_addr];
            if (we) begin
                wr_ptr           <= wr_ptr + 1'b1;
                bus.sample_count <= wr_ptr + 1'b1;
                bus.led          <= 8'(shreg);
            end
            if (state == FULL && bus.frame_ack) begin
                wr_ptr           <= '0;
                bus.sample_count <= '0;
                bus.overflow     <= 1'b0;
            end else if (state == FULL && byte_vld)
                bus.overflow <= 1'b1;
        end
    end

    assign bus.frame_done = state == FULL;
endmodule
